// File: rtl/bcd_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_serial_add_ctrl
//
// Digit-serial BCD adder controller. A request accepted in IDLE latches both
// operands and the carry-in, then adds one BCD digit per cycle (least
// significant first) while the running sum is built up in a register. An
// operand containing a non-BCD digit skips the addition entirely and reports
// err with a zero result.
//
// Ports
//   Clock   : single clock, rising edge
//   Resetn  : synchronous active-low reset
//   start   : request, only looked at while idle
//   A, B    : BCD operands, digit i in bits [4i+3:4i]
//   cin     : carry into digit 0
//   busy    : high whenever an operation is in flight (ADD or DONE)
//   done    : one-cycle pulse, result valid
//   sum     : registered BCD result
//   cout    : registered carry out of the top digit
//   err     : last accepted request had an illegal operand digit
// ---------------------------------------------------------------------------
module bcd_serial_add_ctrl #(
    parameter int NDIG = 4
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              start,
    input  logic [4*NDIG-1:0] A,
    input  logic [4*NDIG-1:0] B,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] sum,
    output logic              cout,
    output logic              err
);

    localparam int              W        = 4 * NDIG;
    localparam int              IDXW     = 3;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);
    localparam logic [W-1:0]    NIB_MASK = W'(4'hF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // True when any nibble of the operand is above 9.
    function automatic logic bcd_has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            bad = bad | (4'(v >> (4 * i)) > 4'd9);
        end
        return bad;
    endfunction

    // One BCD digit add: returns {carry_out, digit}.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                                 input logic [3:0] b,
                                                 input logic       c);
        logic [4:0] t;
        t = {1'b0, a} + {1'b0, b} + {4'd0, c};
        if (t > 5'd9) begin
            return {1'b1, 4'(t - 5'd10)};
        end else begin
            return {1'b0, t[3:0]};
        end
    endfunction

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            carry_q;
    logic            busy_q;
    logic            done_q;
    logic            cout_q;
    logic            err_q;
    logic [IDXW-1:0] idx_q;

    logic [IDXW+1:0] bitpos_s;
    logic [3:0]      digit_a_s;
    logic [3:0]      digit_b_s;
    logic [4:0]      digit_res_s;
    logic [W-1:0]    sum_d;
    logic            operand_bad_s;

    // Pick the digit pair at the current index and merge its result into the sum.
    always_comb begin
        bitpos_s      = {idx_q, 2'b00};
        digit_a_s     = 4'(a_q >> bitpos_s);
        digit_b_s     = 4'(b_q >> bitpos_s);
        digit_res_s   = bcd_digit_add(digit_a_s, digit_b_s, carry_q);
        // Only the nibble at the index is replaced; higher nibbles keep their cleared zero.
        sum_d         = (sum_q & ~(NIB_MASK << bitpos_s)) | (W'(digit_res_s[3:0]) << bitpos_s);
        operand_bad_s = bcd_has_bad_digit(A) | bcd_has_bad_digit(B);
    end

    // Control FSM with all datapath and output registers.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        if (operand_bad_s) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= S_ADD;
                        end
                    end
                end
                S_ADD: begin
                    sum_q   <= sum_d;
                    carry_q <= digit_res_s[4];
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= digit_res_s[4];
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                S_DONE: begin
                    // done is registered, so the pulse appears in the cycle after DONE.
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_serial_add_ctrl
//
// Self-checking bench for bcd_serial_add_ctrl (NDIG = 4). Expected results
// come from plain decimal arithmetic on the operand values; latencies are
// counted in cycles after the accepting edge.
// ---------------------------------------------------------------------------
module tb_bcd_serial_add_ctrl;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic         Clock;
    logic         Resetn;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int checks = 0;
    int errors = 0;

    int           op_lat;
    int           op_busy;
    logic         op_timeout;
    logic [W-1:0] trace [0:31];

    bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .start (start),
        .A     (A),
        .B     (B),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // ---------------- reference model ----------------
    function automatic longint pow10(input int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic has_bad(input logic [W-1:0] v);
        logic bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (4'(v >> (4 * i)) > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic longint bcd_to_int(input logic [W-1:0] v);
        longint r = 0;
        for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + longint'(4'(v >> (4 * i)));
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input longint n);
        logic [W-1:0] r = '0;
        longint       x = n;
        for (int i = 0; i < NDIG; i++) begin
            r = r | (W'(x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                  output logic [W-1:0] es, output logic ec, output logic ee);
        longint total;
        if (has_bad(a) || has_bad(b)) begin
            es = '0; ec = 1'b0; ee = 1'b1;
        end else begin
            total = bcd_to_int(a) + bcd_to_int(b) + longint'(c);
            es = int_to_bcd(total % pow10(NDIG));
            ec = (total >= pow10(NDIG));
            ee = 1'b0;
        end
    endfunction

    function automatic logic [W-1:0] rand_bcd(input logic allow_bad);
        logic [W-1:0] r = '0;
        for (int i = 0; i < NDIG; i++) r = r | (W'($urandom_range(0, 9)) << (4 * i));
        if (allow_bad) r = r | (W'($urandom_range(10, 15)) << (4 * $urandom_range(0, NDIG - 1)));
        return r;
    endfunction

    function automatic logic [W-1:0] low_digits(input logic [W-1:0] v, input int k);
        logic [W-1:0] m = '0;
        for (int j = 0; j < NDIG; j++) begin
            if (j < k) m = m | (W'(4'hF) << (4 * j));
        end
        return v & m;
    endfunction

    // Present a request for one cycle, scramble inputs afterwards, and record
    // cycles-to-done, busy cycles and the sum seen each cycle.
    task automatic issue_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(negedge Clock);
        A = a; B = b; cin = c; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); cin = 1'($urandom);
        op_lat = -1; op_busy = 0; op_timeout = 1'b0;
        for (int k = 0; k < 32; k++) begin
            trace[k] = sum;
            if (busy) op_busy++;
            if (done) begin
                op_lat = k;
                break;
            end
            if (k == 31) op_timeout = 1'b1;
            @(negedge Clock);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Resetn = 1'b0; start = 1'b1; A = 16'h1234; B = 16'h1111; cin = 1'b1;
        repeat (3) @(negedge Clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got %h exp 0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", cout); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        Resetn = 1'b1; start = 1'b0;
        @(negedge Clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4]  = '{16'h1234, 16'h9999, 16'h9999, 16'h12A4};
        logic [W-1:0] vb [4]  = '{16'h5678, 16'h0001, 16'h9999, 16'h0001};
        logic         vc [4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] xs [4]  = '{16'h6912, 16'h0000, 16'h9999, 16'h0000};
        logic         xc [4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic         xe [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        int           xl [4]  = '{5, 5, 5, 1};
        for (int i = 0; i < 4; i++) begin
            issue_op(va[i], vb[i], vc[i]);
            checks++; if (op_lat !== xl[i]) begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, op_lat, xl[i]); end
            checks++; if (op_busy !== xl[i]) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d exp %0d", i, op_busy, xl[i]); end
            checks++; if (sum !== xs[i]) begin errors++; $display("FAIL dir%0d_sum got %h exp %h", i, sum, xs[i]); end
            checks++; if (cout !== xc[i]) begin errors++; $display("FAIL dir%0d_cout got %b exp %b", i, cout, xc[i]); end
            checks++; if (err !== xe[i]) begin errors++; $display("FAIL dir%0d_err got %b exp %b", i, err, xe[i]); end
            @(negedge Clock);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_width got %b exp 0", i, done); end
            repeat (3) @(negedge Clock);
            checks++; if (sum !== xs[i] || cout !== xc[i] || err !== xe[i]) begin
                errors++; $display("FAIL dir%0d_hold got %h/%b/%b exp %h/%b/%b", i, sum, cout, err, xs[i], xc[i], xe[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, es;
        logic         c, ec, ee, bad;
        int           el;
        for (int n = 0; n < 40; n++) begin
            a = rand_bcd($urandom_range(0, 9) == 0);
            b = rand_bcd($urandom_range(0, 9) == 0);
            c = 1'($urandom);
            model(a, b, c, es, ec, ee);
            el = ee ? 1 : NDIG + 1;
            issue_op(a, b, c);
            checks++; if (op_lat !== el) begin errors++; $display("FAIL rnd_latency a=%h b=%h got %0d exp %0d", a, b, op_lat, el); end
            checks++; if (op_busy !== el) begin errors++; $display("FAIL rnd_busy a=%h b=%h got %0d exp %0d", a, b, op_busy, el); end
            checks++; if (sum !== es) begin errors++; $display("FAIL rnd_sum a=%h b=%h c=%b got %h exp %h", a, b, c, sum, es); end
            checks++; if (cout !== ec) begin errors++; $display("FAIL rnd_cout a=%h b=%h c=%b got %b exp %b", a, b, c, cout, ec); end
            checks++; if (err !== ee) begin errors++; $display("FAIL rnd_err a=%h b=%h got %b exp %b", a, b, err, ee); end
            bad = 1'b0;
            for (int k = 0; k <= op_lat && k < 32; k++) begin
                if (trace[k] !== low_digits(es, k)) bad = 1'b1;
            end
            checks++; if (bad) begin errors++; $display("FAIL rnd_partial_sum a=%h b=%h final %h exp %h", a, b, sum, es); end
        end
    endtask

    task automatic test_busy_reject();
        int  seen;
        int  extra;
        @(negedge Clock);
        A = 16'h1234; B = 16'h5678; cin = 1'b0; start = 1'b1;
        @(negedge Clock);
        start = 1'b0; A = 16'h4444; B = 16'h3333; cin = 1'b1;
        @(negedge Clock);
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge Clock);
        end
        checks++; if (seen !== 1) begin errors++; $display("FAIL busy_rej_done got %0d exp 1", seen); end
        checks++; if (sum !== 16'h6912 || cout !== 1'b0) begin errors++; $display("FAIL busy_rej_result got %h/%b exp 6912/0", sum, cout); end
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clock);
            if (done) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL busy_rej_second_done got %0d exp 0", extra); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b, es;
        logic         c, ec, ee;
        int           pulses [$];
        logic [W-1:0] psum [$];
        a = rand_bcd(1'b0); b = rand_bcd(1'b0); c = 1'($urandom);
        model(a, b, c, es, ec, ee);
        @(negedge Clock);
        A = a; B = b; cin = c; start = 1'b1;
        for (int j = 0; j < 22; j++) begin
            @(negedge Clock);
            if (done) begin
                pulses.push_back(j);
                psum.push_back(sum);
            end
        end
        start = 1'b0;
        checks++; if (pulses.size() !== 3) begin errors++; $display("FAIL b2b_pulse_count got %0d exp 3", pulses.size()); end
        for (int i = 1; i < pulses.size(); i++) begin
            checks++; if (pulses[i] - pulses[i-1] !== 6) begin
                errors++; $display("FAIL b2b_gap%0d got %0d exp 6", i, pulses[i] - pulses[i-1]);
            end
        end
        for (int i = 0; i < psum.size(); i++) begin
            checks++; if (psum[i] !== es) begin errors++; $display("FAIL b2b_sum%0d got %h exp %h", i, psum[i], es); end
        end
        repeat (12) @(negedge Clock);
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] a, b, es;
        logic         c, ec, ee;
        int           extra;
        @(negedge Clock);
        A = 16'h5555; B = 16'h5555; cin = 1'b1; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        @(negedge Clock);
        Resetn = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        checks++; if ({busy, done, sum, cout, err} !== '0) begin
            errors++; $display("FAIL midrst_outputs got busy=%b done=%b sum=%h cout=%b err=%b exp all 0", busy, done, sum, cout, err);
        end
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clock);
            if (done) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", extra); end
        a = rand_bcd(1'b0); b = rand_bcd(1'b0); c = 1'($urandom);
        model(a, b, c, es, ec, ee);
        issue_op(a, b, c);
        checks++; if (op_lat !== NDIG + 1) begin errors++; $display("FAIL midrst_fresh_latency got %0d exp %0d", op_lat, NDIG + 1); end
        checks++; if (sum !== es || cout !== ec || err !== 1'b0) begin
            errors++; $display("FAIL midrst_fresh_result got %h/%b/%b exp %h/%b/0", sum, cout, err, es, ec);
        end
    endtask

    initial begin
        Resetn = 1'b0; start = 1'b0; A = '0; B = '0; cin = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_busy_reject();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
